// File: rtl/demux_ctrl_pkg.sv
// Shared definitions for the burst demux dispatcher: channel count, select width
// and the controller state encoding.
package demux_ctrl_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: the first requesting channel after 'last',
// scanning last+1, last+2, ... modulo four.
module rr_pick4
  import demux_ctrl_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any
);

  logic [CH_W-1:0] idx;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    gnt_idx = last;
    idx     = last;
    any     = |req;
    // Walk from the farthest offset down to the nearest so the closest requester wins.
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = last + CH_W'(i);
      if (req[idx]) gnt_idx = idx;
    end
  end

endmodule

// File: rtl/demux_burst_dispatcher.sv
// Shares one valid/ready stream among four consumers, granting one enabled channel
// at a time in round-robin order for a fixed burst of beats.
module demux_burst_dispatcher
  import demux_ctrl_pkg::*;
#(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] out_valid,
  output logic [DW-1:0]     out_data,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [CH_W-1:0]   sel,
  output logic              busy
);

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  state_t          state;
  logic [CH_W-1:0] sel_q;
  logic [CH_W-1:0] last_q;
  logic [7:0]      cnt;
  logic [CH_W-1:0] pick_idx;
  logic            pick_any;
  logic            granted;
  logic            beat;

  rr_pick4 u_pick (
    .req     (en),
    .last    (last_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Reset masks the pass-through so nothing handshakes in the reset cycle.
  assign granted = (state == GRANT) && !rst;
  assign beat    = granted && in_valid && out_ready[sel_q];

  always_comb begin
    out_valid = '0;
    if (granted) out_valid[sel_q] = in_valid;
    in_ready = granted && out_ready[sel_q];
    busy     = granted;
    out_data = in_data;
    sel      = rst ? '0 : sel_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state  <= IDLE;
      sel_q  <= '0;
      last_q <= CH_W'(NUM_CH - 1);
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            sel_q  <= pick_idx;
            last_q <= pick_idx;
            cnt    <= '0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          // A dropped enable still lets this cycle's beat through, then abandons the burst.
          if (!en[sel_q]) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (beat) begin
            if (cnt == BURST_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
